synapse_accumulator: RTL

SYNAPSE_ACCUMULATOR -- requirements
Module: synapse_accumulator

---
 rtl/synapse_accumulator.sv | 110 +++++++++++
 1 files changed

// File: rtl/synapse_accumulator.sv
`default_nettype none
// ============================================================================
// Module      : synapse_accumulator
// Description : Serial weighted spike accumulator; one synapse per enabled cycle
// Revision    : 1.0 - initial release
// ============================================================================
module synapse_accumulator #(
    parameter  int M  = 64,
    parameter  int WB = 4,
    localparam int K  = M / WB,
    localparam int SW = WB + $clog2(K)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 ce,
    input  logic [M-1:0]         weights,
    input  logic [K-1:0]         spikes_in,
    input  logic                 start,
    output logic                 busy,
    output logic                 done,
    output logic signed [SW-1:0] sum
);

    localparam int IW = (K > 1) ? $clog2(K) : 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCUM  = 2'd1,
        FINISH = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic [IW-1:0]         idx_q, idx_d;
    logic signed [SW-1:0]  acc_q, acc_d;
    logic [M-1:0]          wsnap_q, wsnap_d;
    logic [K-1:0]          ssnap_q, ssnap_d;
    logic signed [SW-1:0]  sum_q, sum_d;
    logic                  done_q, done_d;

    logic [WB-1:0]         w_sel;
    logic signed [SW-1:0]  w_ext;

    assign w_sel = wsnap_q[idx_q*WB +: WB];
    assign w_ext = {{(SW-WB){w_sel[WB-1]}}, w_sel};

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        acc_d   = acc_q;
        wsnap_d = wsnap_q;
        ssnap_d = ssnap_q;
        sum_d   = sum_q;
        // done is a strobe: it drops on the next edge even if ce is low
        done_d  = 1'b0;
        if (ce) begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        wsnap_d = weights;
                        ssnap_d = spikes_in;
                        idx_d   = '0;
                        acc_d   = '0;
                        state_d = ACCUM;
                    end
                end
                ACCUM: begin
                    if (ssnap_q[idx_q]) begin
                        acc_d = acc_q + w_ext;
                    end
                    idx_d = idx_q + 1'b1;
                    if (idx_q == IW'(K-1)) begin
                        state_d = FINISH;
                    end
                end
                FINISH: begin
                    sum_d   = acc_q;
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            acc_q   <= '0;
            wsnap_q <= '0;
            ssnap_q <= '0;
            sum_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            acc_q   <= acc_d;
            wsnap_q <= wsnap_d;
            ssnap_q <= ssnap_d;
            sum_q   <= sum_d;
            done_q  <= done_d;
        end
    end

    assign busy = (state_q != IDLE);
    assign done = done_q;
    assign sum  = sum_q;

endmodule
`default_nettype wire
